// File: rtl/fighter_pkg.sv
// Shared fighter-game definitions: reaction states, attack type encoding,
// playfield geometry and default damage values.
// Imported by hit_reaction_ctrl, knockback_axis, player_state and game_resolver.
package fighter_pkg;

   localparam int FP_POS_WIDTH = 10;   // feet position width, unsigned pixels
   localparam int FP_GROUND_Y  = 400;  // floor line, y grows downward
   localparam int FP_DMG_LIGHT = 5;
   localparam int FP_DMG_HEAVY = 10;
   localparam int FP_VEL_WIDTH = 8;    // signed velocity / impulse width

   typedef enum logic [1:0] {
      RS_NORMAL = 2'd0,
      RS_STUN   = 2'd1,
      RS_KO     = 2'd2
   } react_state_e;

   // Attack encoding shared with player_state and game_resolver.
   typedef enum logic [2:0] {
      ATK_NONE        = 3'd0,
      ATK_LIGHT_PUNCH = 3'd1,
      ATK_HEAVY_PUNCH = 3'd2,
      ATK_LIGHT_KICK  = 3'd3,
      ATK_HEAVY_KICK  = 3'd4,
      ATK_SPECIAL     = 3'd5
   } atk_type_e;

   // Heavy attacks map to the heavy damage class on hit.
   function automatic logic atk_is_heavy(input atk_type_e atk);
      return (atk == ATK_HEAVY_PUNCH) || (atk == ATK_HEAVY_KICK) || (atk == ATK_SPECIAL);
   endfunction

endpackage

// File: rtl/knockback_axis.sv
// One axis of knockback motion: pos + vel, clamped to [lo, hi], then velocity update.
// Ports: pos_i/vel_i current state, step_i decay or gravity amount, lo_i/hi_i clamp range;
//        pos_o/vel_o next state, clamped_o set when the raw sum fell outside [lo, hi].
// Purely combinational; the caller owns the registers.
module knockback_axis
   import fighter_pkg::*;
#(
   parameter int W             = FP_POS_WIDTH,
   parameter bit DECAY_MODE    = 1'b1,  // 1: vel moves toward 0 by step; 0: vel += step, sat +127
   parameter bit ZERO_ON_CLAMP = 1'b1   // clear vel before the update when the position clamps
) (
   input  logic [W-1:0]       pos_i,
   input  logic signed [7:0]  vel_i,
   input  logic [7:0]         step_i,
   input  logic [W-1:0]       lo_i,
   input  logic [W-1:0]       hi_i,
   output logic [W-1:0]       pos_o,
   output logic signed [7:0]  vel_o,
   output logic               clamped_o
);

   // Two guard bits so pos + vel can go below 0 or above 2^W-1 without wrapping.
   localparam int SW = W + 2;

   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] lo_s;
   logic signed [SW-1:0] hi_s;
   logic signed [9:0]    vel_base;
   logic signed [9:0]    step_s;
   logic signed [9:0]    vel_tmp;

   always_comb begin
      sum    = $signed({2'b00, pos_i}) + $signed({{(SW-8){vel_i[7]}}, vel_i});
      lo_s   = $signed({2'b00, lo_i});
      hi_s   = $signed({2'b00, hi_i});
      step_s = $signed({2'b00, step_i});

      clamped_o = 1'b0;
      pos_o     = sum[W-1:0];
      if (sum < lo_s) begin
         pos_o     = lo_i;
         clamped_o = 1'b1;
      end else if (sum > hi_s) begin
         pos_o     = hi_i;
         clamped_o = 1'b1;
      end

      vel_base = $signed({{2{vel_i[7]}}, vel_i});
      if (ZERO_ON_CLAMP && clamped_o) begin
         vel_base = '0;
      end

      vel_tmp = '0;
      if (DECAY_MODE) begin
         // Never cross zero: anything within one step of 0 lands on 0.
         if (vel_base > step_s) begin
            vel_tmp = vel_base - step_s;
         end else if (vel_base < -step_s) begin
            vel_tmp = vel_base + step_s;
         end else begin
            vel_tmp = '0;
         end
      end else begin
         vel_tmp = vel_base + step_s;
         if (vel_tmp > 10'sd127) begin
            vel_tmp = 10'sd127;
         end
      end
      vel_o = vel_tmp[7:0];
   end

endmodule

// File: rtl/hit_reaction_ctrl.sv
// Per-player hit reaction: applies resolver hits to health, integrates knockback with
// decay/gravity, and holds NORMAL/STUN/KO. All outputs registered; updates only on SCEN.
// Ports: clk, reset_n (sync, active-low), SCEN frame tick, round_start, hit_event/hit_heavy,
//        hitstun_active, kb_dx/kb_dy impulse, move_dx walk delta; outputs pos_x/pos_y,
//        health, ko, react_state, input_lock, invuln.
// Optional feature macro HIT_REACT_INVULN_EN: post-hit invulnerability window of
// INVULN_FRAMES frames during which hit_event is ignored. Undefined: invuln is 0.
module hit_reaction_ctrl
   import fighter_pkg::*;
#(
   parameter int POS_WIDTH     = FP_POS_WIDTH,
   parameter int START_X       = 160,
   parameter int GROUND_Y      = FP_GROUND_Y,
   parameter int X_MIN         = 8,
   parameter int X_MAX         = 631,
   parameter int GRAVITY       = 1,
   parameter int KB_DECAY      = 1,
   parameter int HEALTH        = 100,
   parameter int DMG_LIGHT     = FP_DMG_LIGHT,
   parameter int DMG_HEAVY     = FP_DMG_HEAVY,
   parameter int INVULN_FRAMES = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 SCEN,
   input  logic                 round_start,
   input  logic                 hit_event,
   input  logic                 hit_heavy,
   input  logic                 hitstun_active,
   input  logic signed [7:0]    kb_dx,
   input  logic signed [7:0]    kb_dy,
   input  logic signed [7:0]    move_dx,
   output logic [POS_WIDTH-1:0] pos_x,
   output logic [POS_WIDTH-1:0] pos_y,
   output logic [7:0]           health,
   output logic                 ko,
   output logic [1:0]           react_state,
   output logic                 input_lock,
   output logic                 invuln
);

   localparam logic [POS_WIDTH-1:0] START_X_P  = POS_WIDTH'(START_X);
   localparam logic [POS_WIDTH-1:0] GROUND_P   = POS_WIDTH'(GROUND_Y);
   localparam logic [POS_WIDTH-1:0] X_MIN_P    = POS_WIDTH'(X_MIN);
   localparam logic [POS_WIDTH-1:0] X_MAX_P    = POS_WIDTH'(X_MAX);
   localparam logic [7:0]           HEALTH_P   = 8'(HEALTH);
   localparam logic [7:0]           DMG_L_P    = 8'(DMG_LIGHT);
   localparam logic [7:0]           DMG_H_P    = 8'(DMG_HEAVY);

   react_state_e           state_q, state_d;
   logic [POS_WIDTH-1:0]   pos_x_q, pos_x_d;
   logic [POS_WIDTH-1:0]   pos_y_q, pos_y_d;
   logic signed [7:0]      vel_x_q, vel_x_d;
   logic signed [7:0]      vel_y_q, vel_y_d;
   logic [7:0]             health_q, health_d;
   logic                   ko_q;
   logic                   lock_q;

   logic                   inv_active;
   logic                   hit_ok;
   logic [7:0]             dmg;
   logic                   stun_done;

`ifdef HIT_REACT_INVULN_EN
   localparam logic [7:0]  INV_P = 8'(INVULN_FRAMES);
   logic [7:0]             inv_cnt_q, inv_cnt_d;
   logic                   invuln_q;
   assign inv_active = invuln_q;
   assign invuln     = invuln_q;
`else
   assign inv_active = 1'b0;
   assign invuln     = 1'b0;
`endif

   // In NORMAL the X axis carries the walk delta instead of knockback velocity.
   logic signed [7:0]      x_vel_in;
   logic [POS_WIDTH-1:0]   x_pos_nxt, y_pos_nxt;
   logic signed [7:0]      x_vel_nxt, y_vel_nxt;
   logic                   x_clamped, y_clamped;

   assign x_vel_in = (state_q == RS_NORMAL) ? move_dx : vel_x_q;

   knockback_axis #(
      .W             (POS_WIDTH),
      .DECAY_MODE    (1'b1),
      .ZERO_ON_CLAMP (1'b1)
   ) u_axis_x (
      .pos_i     (pos_x_q),
      .vel_i     (x_vel_in),
      .step_i    (8'(KB_DECAY)),
      .lo_i      (X_MIN_P),
      .hi_i      (X_MAX_P),
      .pos_o     (x_pos_nxt),
      .vel_o     (x_vel_nxt),
      .clamped_o (x_clamped)
   );

   // Y range is [0, GROUND_Y]; landing and ceiling contact are handled below.
   knockback_axis #(
      .W             (POS_WIDTH),
      .DECAY_MODE    (1'b0),
      .ZERO_ON_CLAMP (1'b0)
   ) u_axis_y (
      .pos_i     (pos_y_q),
      .vel_i     (vel_y_q),
      .step_i    (8'(GRAVITY)),
      .lo_i      ('0),
      .hi_i      (GROUND_P),
      .pos_o     (y_pos_nxt),
      .vel_o     (y_vel_nxt),
      .clamped_o (y_clamped)
   );

   always_comb begin
      state_d   = state_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      vel_x_d   = vel_x_q;
      vel_y_d   = vel_y_q;
      health_d  = health_q;
`ifdef HIT_REACT_INVULN_EN
      inv_cnt_d = inv_cnt_q;
`endif
      hit_ok    = hit_event && (state_q != RS_KO) && !inv_active;
      dmg       = hit_heavy ? DMG_H_P : DMG_L_P;
      // Exit test uses the state at the start of the frame.
      stun_done = !hitstun_active && (pos_y_q == GROUND_P) && (vel_x_q == '0);

      if (round_start) begin
         state_d   = RS_NORMAL;
         pos_x_d   = START_X_P;
         pos_y_d   = GROUND_P;
         vel_x_d   = '0;
         vel_y_d   = '0;
         health_d  = HEALTH_P;
`ifdef HIT_REACT_INVULN_EN
         inv_cnt_d = '0;
`endif
      end else if (SCEN) begin
`ifdef HIT_REACT_INVULN_EN
         if (hit_ok) begin
            inv_cnt_d = INV_P;
         end else if (inv_cnt_q != '0) begin
            inv_cnt_d = inv_cnt_q - 8'd1;
         end
`endif
         if (hit_ok) begin
            // A hit freezes position for this frame; knockback starts next frame.
            health_d = (health_q <= dmg) ? 8'd0 : health_q - dmg;
            vel_x_d  = kb_dx;
            vel_y_d  = kb_dy;
            state_d  = (health_d == 8'd0) ? RS_KO : RS_STUN;
         end else if (state_q == RS_NORMAL) begin
            pos_x_d = x_pos_nxt;
            pos_y_d = GROUND_P;
            vel_x_d = '0;
            vel_y_d = '0;
         end else begin
            pos_x_d = x_pos_nxt;
            vel_x_d = x_vel_nxt;
            pos_y_d = y_pos_nxt;
            // Touching the floor (landing) or the top edge stops vertical motion.
            if (y_clamped || (y_pos_nxt == GROUND_P)) begin
               vel_y_d = '0;
            end else begin
               vel_y_d = y_vel_nxt;
            end
            if ((state_q == RS_STUN) && stun_done) begin
               state_d = RS_NORMAL;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= RS_NORMAL;
         pos_x_q   <= START_X_P;
         pos_y_q   <= GROUND_P;
         vel_x_q   <= '0;
         vel_y_q   <= '0;
         health_q  <= HEALTH_P;
         ko_q      <= 1'b0;
         lock_q    <= 1'b0;
`ifdef HIT_REACT_INVULN_EN
         inv_cnt_q <= '0;
         invuln_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         vel_x_q   <= vel_x_d;
         vel_y_q   <= vel_y_d;
         health_q  <= health_d;
         ko_q      <= (state_d == RS_KO);
         lock_q    <= (state_d != RS_NORMAL);
`ifdef HIT_REACT_INVULN_EN
         inv_cnt_q <= inv_cnt_d;
         invuln_q  <= (inv_cnt_d != '0);
`endif
      end
   end

   assign pos_x       = pos_x_q;
   assign pos_y       = pos_y_q;
   assign health      = health_q;
   assign ko          = ko_q;
   assign react_state = state_q;
   assign input_lock  = lock_q;

endmodule

// File: tb/tb_hit_reaction_ctrl.sv
// Testbench for hit_reaction_ctrl: directed scenarios plus randomized traffic, every
// output compared each cycle against a frame-level reference model of the player.
// Build with HIT_REACT_INVULN_EN defined to also cover the invulnerability window.
module tb_hit_reaction_ctrl;

   localparam int START_X  = 160;
   localparam int GROUND_Y = 400;
   localparam int X_MIN    = 8;
   localparam int X_MAX    = 631;
   localparam int HEALTH   = 100;
   localparam int DMG_L    = 5;
   localparam int DMG_H    = 10;
   localparam int INV_LEN  = 8;

   logic              clk = 1'b0;
   logic              reset_n, scen, round_start, hit_event, hit_heavy, hitstun;
   logic signed [7:0] kb_dx, kb_dy, move_dx;
   logic [9:0]        pos_x, pos_y;
   logic [7:0]        health;
   logic              ko, input_lock, invuln;
   logic [1:0]        react_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: plain integers, state 0=NORMAL 1=STUN 2=KO.
   int m_x, m_y, m_vx, m_vy, m_hp, m_st, m_inv;

   always #5 clk = ~clk;

   hit_reaction_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .SCEN           (scen),
      .round_start    (round_start),
      .hit_event      (hit_event),
      .hit_heavy      (hit_heavy),
      .hitstun_active (hitstun),
      .kb_dx          (kb_dx),
      .kb_dy          (kb_dy),
      .move_dx        (move_dx),
      .pos_x          (pos_x),
      .pos_y          (pos_y),
      .health         (health),
      .ko             (ko),
      .react_state    (react_state),
      .input_lock     (input_lock),
      .invuln         (invuln)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_x = START_X; m_y = GROUND_Y; m_vx = 0; m_vy = 0;
      m_hp = HEALTH; m_st = 0; m_inv = 0;
   endtask

   // One clock edge of the player, written from the frame rules.
   task automatic model_step();
      int  dmg, nx, ny, dx, dy, mv;
      bit  hit, leave, inv_on;
      dx = kb_dx; dy = kb_dy; mv = move_dx;
`ifdef HIT_REACT_INVULN_EN
      inv_on = (m_inv != 0);
`else
      inv_on = 1'b0;
`endif
      if (!reset_n || round_start) begin
         model_reset();
      end else if (scen) begin
         hit = hit_event && (m_st != 2) && !inv_on;
         if (hit) m_inv = INV_LEN;
         else if (m_inv > 0) m_inv--;
         if (hit) begin
            dmg  = hit_heavy ? DMG_H : DMG_L;
            m_hp = (m_hp <= dmg) ? 0 : m_hp - dmg;
            m_vx = dx; m_vy = dy;
            m_st = (m_hp == 0) ? 2 : 1;
         end else if (m_st == 0) begin
            nx = m_x + mv;
            m_x = (nx < X_MIN) ? X_MIN : (nx > X_MAX) ? X_MAX : nx;
            m_y = GROUND_Y;
         end else begin
            leave = (m_st == 1) && !hitstun && (m_y == GROUND_Y) && (m_vx == 0);
            nx = m_x + m_vx;
            if (nx < X_MIN || nx > X_MAX) begin
               nx = (nx < X_MIN) ? X_MIN : X_MAX;
               m_vx = 0;
            end
            m_x = nx;
            if (m_vx > 0) m_vx--;
            else if (m_vx < 0) m_vx++;
            ny = m_y + m_vy;
            m_vy = (m_vy + 1 > 127) ? 127 : m_vy + 1;
            if (ny >= GROUND_Y) begin
               ny = GROUND_Y; m_vy = 0;
            end else if (ny < 0) begin
               ny = 0; m_vy = 0;
            end
            m_y = ny;
            if (leave) m_st = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("pos_x",       int'(pos_x), m_x);
      check("pos_y",       int'(pos_y), m_y);
      check("health",      int'(health), m_hp);
      check("react_state", int'(react_state), m_st);
      check("ko",          int'(ko), int'(m_st == 2));
      check("input_lock",  int'(input_lock), int'(m_st != 0));
`ifdef HIT_REACT_INVULN_EN
      check("invuln",      int'(invuln), int'(m_inv != 0));
`else
      check("invuln",      int'(invuln), 0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      scen = 1'b0; round_start = 1'b0; hit_event = 1'b0; hit_heavy = 1'b0;
      hitstun = 1'b0; kb_dx = '0; kb_dy = '0; move_dx = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   // One SCEN frame followed by one idle clock.
   task automatic frame(input int mv, input bit hit, input bit heavy, input bit hs,
                        input int kdx, input int kdy);
      scen = 1'b1; move_dx = 8'(mv); hit_event = hit; hit_heavy = heavy;
      hitstun = hs; kb_dx = 8'(kdx); kb_dy = 8'(kdy);
      tick();
      scen = 1'b0; hit_event = 1'b0;
      tick();
   endtask

   int exp_x[3] = '{163, 165, 166};

   initial begin
      // Reset state
      clear_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      check("rst_pos_x", int'(pos_x), START_X);
      check("rst_pos_y", int'(pos_y), GROUND_Y);
      check("rst_health", int'(health), HEALTH);
      check("rst_state", int'(react_state), 0);
      reset_n = 1'b1;

      // Walking
      repeat (4) frame(3, 0, 0, 0, 0, 0);
      check("t1_pos_x", int'(pos_x), 172);
      check("t1_pos_y", int'(pos_y), 400);
      check("t1_state", int'(react_state), 0);
      check("t1_health", int'(health), 100);

      // Light hit with knockback and a 12-frame hitstun
      do_reset();
      frame(0, 1, 0, 1, 3, -2);
      check("t2_health", int'(health), 95);
      check("t2_state", int'(react_state), 1);
      check("t2_lock", int'(input_lock), 1);
      for (int i = 1; i <= 11; i++) begin
         frame(0, 0, 0, 1, 0, 0);
         if (i <= 3) check("t2_kb_x", int'(pos_x), exp_x[i-1]);
      end
      check("t2_held_x", int'(pos_x), 166);
      check("t2_still_stun", int'(react_state), 1);
      frame(0, 0, 0, 0, 0, 0);
      check("t2_normal", int'(react_state), 0);
      check("t2_landed_y", int'(pos_y), 400);

      // Right-edge clamp
      do_reset();
      repeat (3) frame(127, 0, 0, 0, 0, 0);
      frame(89, 0, 0, 0, 0, 0);
      check("t3_pre_x", int'(pos_x), 630);
      frame(0, 1, 0, 0, 5, 0);
      frame(0, 0, 0, 0, 0, 0);
      check("t3_clamp_x", int'(pos_x), 631);
      frame(0, 0, 0, 0, 0, 0);
      check("t3_after_x", int'(pos_x), 631);
      check("t3_state", int'(react_state), 0);

      // Health to zero, KO, hits ignored, round_start recovers
      do_reset();
      for (int h = 0; h < 9; h++) begin
         frame(0, 1, 1, 0, 0, 0);
         repeat (8) frame(0, 0, 0, 0, 0, 0);
      end
      check("t4_h10", int'(health), 10);
      frame(0, 1, 0, 0, 0, 0);
      check("t4_h5", int'(health), 5);
      repeat (8) frame(0, 0, 0, 0, 0, 0);
      frame(0, 1, 1, 0, 0, 0);
      check("t4_h0", int'(health), 0);
      check("t4_ko", int'(ko), 1);
      check("t4_state_ko", int'(react_state), 2);
      repeat (8) frame(0, 0, 0, 0, 0, 0);
      frame(0, 1, 1, 0, 4, -3);
      check("t4_ko_hit_h", int'(health), 0);
      check("t4_ko_hold", int'(react_state), 2);
      repeat (6) frame(0, 0, 0, 0, 0, 0);
      round_start = 1'b1;
      tick();
      round_start = 1'b0;
      check("t4_rs_health", int'(health), 100);
      check("t4_rs_pos_x", int'(pos_x), 160);
      check("t4_rs_ko", int'(ko), 0);

      // round_start beats a same-cycle hit; non-SCEN hit is ignored
      do_reset();
      repeat (2) frame(20, 0, 0, 0, 0, 0);
      scen = 1'b1; round_start = 1'b1; hit_event = 1'b1; hit_heavy = 1'b1; kb_dx = 8'sd50;
      tick();
      clear_inputs();
      check("t5_health", int'(health), 100);
      check("t5_pos_x", int'(pos_x), 160);
      check("t5_state", int'(react_state), 0);
      hit_event = 1'b1; hit_heavy = 1'b1; kb_dx = 8'sd9;
      tick();
      tick();
      clear_inputs();
      check("t5_noscen_h", int'(health), 100);
      check("t5_noscen_st", int'(react_state), 0);

`ifdef HIT_REACT_INVULN_EN
      // Invulnerability window
      do_reset();
      frame(0, 1, 0, 0, 0, 0);
      check("t6_invuln", int'(invuln), 1);
      check("t6_h95", int'(health), 95);
      repeat (2) frame(0, 0, 0, 0, 0, 0);
      frame(0, 1, 0, 0, 0, 0);
      check("t6_ignored", int'(health), 95);
      repeat (5) frame(0, 0, 0, 0, 0, 0);
      frame(0, 1, 0, 0, 0, 0);
      check("t6_applied", int'(health), 90);
`endif

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset_n     = ($urandom_range(0, 199) != 0);
         round_start = ($urandom_range(0, 99) == 0);
         scen        = ($urandom_range(0, 3) != 0);
         hit_event   = ($urandom_range(0, 9) == 0);
         hit_heavy   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) hitstun = ~hitstun;
         kb_dx       = 8'($urandom_range(0, 255));
         kb_dy       = 8'(int'($urandom_range(0, 40)) - 20);
         move_dx     = 8'($urandom_range(0, 255));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
